// File: rtl/mitchell_log_mult_pipe.sv
// Streaming Mitchell logarithmic multiplier.
// The three register stages are:
//   1. leading-one detect and normalise
//   2. log-domain add
//   3. antilog shift with sign/zero fix-up
// Every stage advances together whenever the output is free or being consumed.
module mitchell_log_mult_pipe #(
   parameter int N   = 16,
   parameter int W   = 8,
   parameter int LGN = $clog2(N)
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic           i_signed,
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [2*N-1:0] o_z
);

   localparam int F  = W - 1;
   localparam int LW = LGN + W;
   localparam int SW = 2 * N + W;

   // Two's complement operands are folded to magnitude; the most negative value maps onto 2^(N-1).
   function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic sgn);
      magnitude = (sgn && x[N-1]) ? (~x + 1'b1) : x;
   endfunction

   // Highest set bit wins because later iterations overwrite earlier ones.
   function automatic logic [LGN-1:0] lead_one(input logic [N-1:0] x);
      lead_one = '0;
      for (int i = 0; i < N; i++) begin
         if (x[i]) lead_one = i[LGN-1:0];
      end
   endfunction

   // Shift the leading one up to bit N-1, then keep the next F bits (truncated, never rounded).
   function automatic logic [F-1:0] mantissa(input logic [N-1:0] x, input logic [LGN-1:0] k);
      logic [N-1:0] norm;
      norm     = x << (LGN'(N - 1) - k);
      mantissa = norm[N-2 -: F];
   endfunction

   logic           en;

   logic [N-1:0]   mag_a;
   logic [N-1:0]   mag_b;
   logic [LGN-1:0] k_a;
   logic [LGN-1:0] k_b;
   logic [F-1:0]   f_a;
   logic [F-1:0]   f_b;
   logic [LW-1:0]  log_sum;
   logic [SW-1:0]  shifted;
   logic [2*N-1:0] result;

   logic           s1_valid_q, s1_valid_d;
   logic           s1_sign_q,  s1_sign_d;
   logic           s1_zero_q,  s1_zero_d;
   logic [LGN-1:0] s1_ka_q,    s1_ka_d;
   logic [LGN-1:0] s1_kb_q,    s1_kb_d;
   logic [F-1:0]   s1_fa_q,    s1_fa_d;
   logic [F-1:0]   s1_fb_q,    s1_fb_d;

   logic           s2_valid_q, s2_valid_d;
   logic           s2_sign_q,  s2_sign_d;
   logic           s2_zero_q,  s2_zero_d;
   logic [LW-1:0]  s2_l_q,     s2_l_d;

   logic           o_valid_q,  o_valid_d;
   logic [2*N-1:0] o_z_q,      o_z_d;

   assign en      = !o_valid_q || i_ready;
   assign o_ready = en;
   assign o_valid = o_valid_q;
   assign o_z     = o_z_q;

   // Stage 1 datapath: operand magnitudes, their characteristics and truncated mantissas.
   always_comb begin
      mag_a = magnitude(i_a, i_signed);
      mag_b = magnitude(i_b, i_signed);
      k_a   = lead_one(mag_a);
      k_b   = lead_one(mag_b);
      f_a   = mantissa(mag_a, k_a);
      f_b   = mantissa(mag_b, k_b);
   end

   // Stages 2 and 3 datapath: the log add, whose fraction carry ripples into the characteristic, then the antilog shift.
   always_comb begin
      log_sum = {1'b0, s1_ka_q, s1_fa_q} + {1'b0, s1_kb_q, s1_fb_q};
      shifted = ({{(SW-W){1'b0}}, 1'b1, s2_l_q[F-1:0]} << s2_l_q[LW-1:F]) >> F;
      if (s2_zero_q)
         result = '0;
      else if (s2_sign_q)
         result = ~shifted[2*N-1:0] + 1'b1;
      else
         result = shifted[2*N-1:0];
   end

   // Next-state for all stages: hold everything on a stall, shift bubbles along otherwise.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_zero_d  = s1_zero_q;
      s1_ka_d    = s1_ka_q;
      s1_kb_d    = s1_kb_q;
      s1_fa_d    = s1_fa_q;
      s1_fb_d    = s1_fb_q;
      s2_valid_d = s2_valid_q;
      s2_sign_d  = s2_sign_q;
      s2_zero_d  = s2_zero_q;
      s2_l_d     = s2_l_q;
      o_valid_d  = o_valid_q;
      o_z_d      = o_z_q;
      if (en) begin
         s1_valid_d = i_valid;
         s1_sign_d  = i_signed && (i_a[N-1] ^ i_b[N-1]);
         s1_zero_d  = (mag_a == '0) || (mag_b == '0);
         s1_ka_d    = k_a;
         s1_kb_d    = k_b;
         s1_fa_d    = f_a;
         s1_fb_d    = f_b;
         s2_valid_d = s1_valid_q;
         s2_sign_d  = s1_sign_q;
         s2_zero_d  = s1_zero_q;
         s2_l_d     = log_sum;
         o_valid_d  = s2_valid_q;
         if (s2_valid_q) o_z_d = result;
      end
   end

   // Pipeline registers; reset drops every in-flight transaction and clears the output.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_ka_q    <= '0;
         s1_kb_q    <= '0;
         s1_fa_q    <= '0;
         s1_fb_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_zero_q  <= 1'b0;
         s2_l_q     <= '0;
         o_valid_q  <= 1'b0;
         o_z_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_zero_q  <= s1_zero_d;
         s1_ka_q    <= s1_ka_d;
         s1_kb_q    <= s1_kb_d;
         s1_fa_q    <= s1_fa_d;
         s1_fb_q    <= s1_fb_d;
         s2_valid_q <= s2_valid_d;
         s2_sign_q  <= s2_sign_d;
         s2_zero_q  <= s2_zero_d;
         s2_l_q     <= s2_l_d;
         o_valid_q  <= o_valid_d;
         o_z_q      <= o_z_d;
      end
   end

endmodule

// File: tb/tb_mitchell_log_mult_pipe.sv
// Directed bench for the pipelined Mitchell multiplier at N=16, W=8.
// Results are checked in order against a table of hand-computed products.
module tb_mitchell_log_mult_pipe;

   localparam int N = 16;
   localparam int W = 8;

   logic           i_clk = 1'b0;
   logic           i_rst_n;
   logic           i_valid;
   logic           o_ready;
   logic           i_signed;
   logic [N-1:0]   i_a;
   logic [N-1:0]   i_b;
   logic           o_valid;
   logic           i_ready;
   logic [2*N-1:0] o_z;

   typedef struct {
      logic        sgn;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] z;
   } vec_t;

   vec_t        vecs[16];
   logic [31:0] exp_q[$];
   int          xfer_cycle[$];
   int          checks = 0;
   int          fails = 0;
   int          cycle = 0;
   int          first_accept_cycle = -1;
   bit          sb_on = 1'b0;

   mitchell_log_mult_pipe #(.N(N), .W(W)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_signed (i_signed),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_z      (o_z)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 i_clk = ~i_clk;

   // Cycle count, used to measure latency and back-to-back output spacing.
   always @(posedge i_clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Scoreboard: each output transfer must match the oldest outstanding expected result.
   always @(negedge i_clk) begin
      if (sb_on && i_rst_n && o_valid && i_ready) begin
         xfer_cycle.push_back(cycle);
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_output: got 0x%08h, expected no output", o_z);
         end else begin
            checkOutput("ordered_result", o_z, exp_q.pop_front());
         end
      end
   end

   // Present one operand pair until it is accepted; leaves i_valid high for back-to-back use.
   task automatic applyStimulus(input int idx);
      bit accepted;
      accepted = 1'b0;
      i_valid  = 1'b1;
      i_signed = vecs[idx].sgn;
      i_a      = vecs[idx].a;
      i_b      = vecs[idx].b;
      for (int t = 0; t < 50 && !accepted; t++) begin
         @(negedge i_clk);
         if (o_ready) begin
            accepted = 1'b1;
            exp_q.push_back(vecs[idx].z);
            if (first_accept_cycle < 0) first_accept_cycle = cycle;
         end
         @(posedge i_clk);
         #1;
      end
      if (!accepted) begin
         checks++;
         fails++;
         $display("[TB] FAIL accept_timeout: got o_ready=0 for 50 cycles, expected acceptance");
      end
   endtask

   task automatic waitDrain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge i_clk);
         #1;
         t++;
      end
      checkOutput("drain_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Watchdog so that a wedged pipeline still terminates the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seen;

      vecs[0]  = '{1'b0, 16'd3,     16'd5,     32'h0000_000E};
      vecs[1]  = '{1'b0, 16'd256,   16'd256,   32'h0001_0000};
      vecs[2]  = '{1'b0, 16'hFFFF,  16'hFFFF,  32'hFE00_0000};
      vecs[3]  = '{1'b1, 16'hFFFD,  16'd5,     32'hFFFF_FFF2};
      vecs[4]  = '{1'b1, 16'h8000,  16'h0002,  32'hFFFF_0000};
      vecs[5]  = '{1'b1, 16'h0000,  16'h8000,  32'h0000_0000};
      vecs[6]  = '{1'b0, 16'd0,     16'd7,     32'h0000_0000};
      vecs[7]  = '{1'b0, 16'd1,     16'd1,     32'h0000_0001};
      vecs[8]  = '{1'b0, 16'd7,     16'd7,     32'h0000_0030};
      vecs[9]  = '{1'b0, 16'd6,     16'd3,     32'h0000_0010};
      vecs[10] = '{1'b1, 16'hFFFF,  16'hFFFF,  32'h0000_0001};
      vecs[11] = '{1'b1, 16'hFFFF,  16'h0001,  32'hFFFF_FFFF};
      vecs[12] = '{1'b0, 16'h8000,  16'h8000,  32'h4000_0000};
      vecs[13] = '{1'b1, 16'h8000,  16'h8000,  32'h4000_0000};
      vecs[14] = '{1'b0, 16'h01FF,  16'h0001,  32'h0000_01FE};
      vecs[15] = '{1'b0, 16'd5,     16'h0100,  32'h0000_0500};

      i_rst_n  = 1'b0;
      i_valid  = 1'b0;
      i_signed = 1'b0;
      i_a      = '0;
      i_b      = '0;
      i_ready  = 1'b1;

      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
      checkOutput("reset_o_z", o_z, 32'd0);
      checkOutput("reset_o_ready", 32'(o_ready), 32'd1);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;

      // Latency: a single pair accepted at edge A must show o_valid only after edge A+2.
      i_valid  = 1'b1;
      i_signed = vecs[0].sgn;
      i_a      = vecs[0].a;
      i_b      = vecs[0].b;
      @(negedge i_clk);
      checkOutput("latency_o_ready", 32'(o_ready), 32'd1);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      @(negedge i_clk);
      checkOutput("latency_cycle1_valid", 32'(o_valid), 32'd0);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      checkOutput("latency_cycle2_valid", 32'(o_valid), 32'd0);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      checkOutput("latency_cycle3_valid", 32'(o_valid), 32'd1);
      checkOutput("latency_cycle3_o_z", o_z, vecs[0].z);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      checkOutput("bubble_o_valid", 32'(o_valid), 32'd0);
      checkOutput("bubble_o_z_held", o_z, vecs[0].z);
      @(posedge i_clk);
      #1;

      // Table of single transactions, each drained before the next is sent.
      sb_on = 1'b1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(i);
         i_valid = 1'b0;
         waitDrain();
      end

      // Eight back-to-back pairs: outputs begin 3 cycles after the first accept and stay contiguous.
      xfer_cycle.delete();
      first_accept_cycle = -1;
      for (int i = 0; i < 8; i++) applyStimulus(i);
      i_valid = 1'b0;
      waitDrain();
      checkOutput("stream_count", 32'(xfer_cycle.size()), 32'd8);
      if (xfer_cycle.size() == 8) begin
         checkOutput("stream_first_cycle", 32'(xfer_cycle[0]), 32'(first_accept_cycle + 3));
         checkOutput("stream_span", 32'(xfer_cycle[7] - xfer_cycle[0]), 32'd7);
      end

      // Stall a full pipeline for four cycles while the upstream keeps offering data.
      xfer_cycle.delete();
      fork
         begin
            for (int i = 8; i < 16; i++) applyStimulus(i);
            i_valid = 1'b0;
         end
         begin
            int t;
            t = 0;
            while (!o_valid && t < 20) begin
               @(posedge i_clk);
               #1;
               t++;
            end
            @(posedge i_clk);
            #1;
            i_ready = 1'b0;
            for (int c = 0; c < 4; c++) begin
               @(negedge i_clk);
               checkOutput("stall_o_ready", 32'(o_ready), 32'd0);
               checkOutput("stall_o_valid", 32'(o_valid), 32'd1);
               if (exp_q.size() != 0)
                  checkOutput("stall_o_z", o_z, exp_q[0]);
               @(posedge i_clk);
               #1;
            end
            i_ready = 1'b1;
         end
      join
      waitDrain();
      checkOutput("stall_total_outputs", 32'(xfer_cycle.size()), 32'd8);

      // Reset with two pairs in flight: outputs clear at once and neither pair reappears.
      applyStimulus(3);
      applyStimulus(4);
      i_valid = 1'b0;
      #2;
      i_rst_n = 1'b0;
      sb_on   = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("midrst_o_valid", 32'(o_valid), 32'd0);
      checkOutput("midrst_o_z", o_z, 32'd0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge i_clk);
         if (o_valid) seen++;
      end
      checkOutput("midrst_no_ghost_outputs", 32'(seen), 32'd0);
      checkOutput("midrst_o_z_after", o_z, 32'd0);
      @(posedge i_clk);
      #1;

      // The pipe must still work normally after the mid-stream reset.
      sb_on = 1'b1;
      applyStimulus(14);
      i_valid = 1'b0;
      waitDrain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mitchell_log_mult_pipe.md
Name: mitchell_log_mult_pipe

Overview:
Pipelined, parametrised Mitchell logarithmic multiplier with valid/ready flow control and a per-transaction unsigned/signed mode. Three register stages: leading-one detect and normalise, log-domain add, then antilog shift with sign/zero fix-up. Sits in the approximate-arithmetic datapath and is the streaming successor of the combinational 16-bit Mitchell core. Accepts one operand pair per cycle when not stalled.

Parameters:
N, 16, operand width in bits; power of 2, 4..32.
W, 8, kept mantissa width including the implicit leading one; fraction width is W-1; 2 <= W <= N.
LGN, $clog2(N), characteristic width; derived, do not override.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  upstream operand pair valid.
o_ready  output  1  block can accept a pair this cycle.
i_signed  input  1  1 = operands are two's complement, 0 = unsigned; sampled with the operands.
i_a  input  N  operand A.
i_b  input  N  operand B.
o_valid  output  1  o_z valid.
i_ready  input  1  downstream accepts o_z.
o_z  output  2N  approximate product; two's complement when the transaction's i_signed = 1.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, o_valid = 0, o_z = 0. Reset mid-stream discards in-flight data; no output is produced for it.
- Flow control: en = !o_valid | i_ready; o_ready = en. Transfer in when i_valid & o_ready; out when o_valid & i_ready. On en, all stages shift together, including bubbles; on !en, every stage holds.
- Latency: exactly 3 cycles from accept to o_valid with no stall; throughput 1 per cycle while i_ready = 1.
- Stage 1:
  - Magnitude: if i_signed, |x| as an N-bit unsigned value (-2^(N-1) maps to 2^(N-1)), sign = a_msb ^ b_msb; else magnitude = x and sign = 0.
  - k = index of the leading one (0..N-1).
  - f = magnitude bits below the leading one, left-aligned into N-1 bits; keep the top W-1 bits, truncating and not rounding; zero-fill when k < W-1.
  - zero flag = (magA == 0) | (magB == 0).
- Stage 2: L = {1'b0, kA, fA} + {1'b0, kB, fB}, width LGN+W. charac = L[LGN+W-1:W-1] (0..2N-1). frac = L[W-2:0]. A fraction carry propagates into charac.
- Stage 3:
  - mag = ({1'b1, frac} << charac) >> (W-1), computed in at least 2N+W bits and truncated to 2N.
  - If zero flag: o_z = 0 and the sign is ignored.
  - Else: o_z = sign ? -mag : mag, 2N-bit two's complement.
- No exact-product correction term; the error is the pure Mitchell error plus mantissa truncation.
- i_valid = 0 inserts a bubble; o_z holds its last value while o_valid = 0.
- Stall (o_valid = 1, i_ready = 0): o_z, o_valid and all stages are stable, and no input is accepted.

Test Plan:
- N=16, W=8, unsigned, a=3, b=5 -> after 3 cycles o_valid=1, o_z=14 (0x0000000E).
- Unsigned a=256, b=256 -> o_z=65536; a=65535, b=65535 -> o_z=0xFE000000 (fraction carry into charac gives charac 31, frac 126).
- Signed, a=0xFFFD (-3), b=5 -> o_z=0xFFFFFFF2 (-14); a=0x8000, b=0x0002 -> o_z=0xFFFF0000 (-65536); a=0, b=0x8000 -> o_z=0.
- Stream of 8 back-to-back pairs with i_ready=1 -> 8 consecutive o_valid cycles starting 3 cycles after the first accept, results in order.
- Hold i_ready=0 for 4 cycles with a full pipe -> o_ready=0, o_z/o_valid stable; release -> remaining results emerge in order with none lost or duplicated.
- Assert i_rst_n=0 with 2 pairs in flight -> o_valid=0 and o_z=0 immediately; after release, neither discarded pair appears on the output.
